// File: rtl/tristate_bus_pkg.sv
// tristate_bus_pkg
// Shared definitions for the tristate bus port: the FSM state encoding and
// the helper that sizes the cycle counter from the timing parameters.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        SETTLE = 2'd3
    } bus_state_t;

    // Width that holds the largest load value (max - 1), with one bit of
    // headroom; the counter is reloaded on every state entry so it never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/tristate_bus_port_counter.sv
// bus_cycle_counter
// Load / decrement / zero-detect down counter shared by every timed state of
// the tristate bus port.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load, load_val  reload the counter (takes priority over dec)
//   dec             decrement by one, holds at zero
//   zero            terminal-count flag, count == 0
module bus_cycle_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tristate_bus_port.sv
// tristate_bus_port
// Single-master port driving a resistor-terminated shared bus through tristate
// outputs. Every drive is followed by a Z turnaround gap and every read is
// preceded by a Z settle delay, so the termination defines the idle level.
//
// Optional feature macro: BUS_CHECK_EN
//   defined   -> the bus is read back on the last DRIVE cycle and any mismatch
//                (including x/z bits) sets the sticky err flag
//   undefined -> no readback check, err is tied low
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_valid/wr_data    write request and value; accepted when wr_ready is high
//   wr_ready            high only in IDLE
//   rd_req              read request level
//   rd_done/rd_data     one-cycle completion pulse and captured bus value
//   bus_drv             tristate driver onto the terminated bus
//   bus_in              resolved bus value read back
//   busy                high outside IDLE
//   err                 sticky readback mismatch flag
//
// state  | meaning
// IDLE   | bus released, accepting a write or a read
// DRIVE  | latched write data on the bus for DRIVE_CYCLES
// TURN   | bus released for TURN_CYCLES before the next transaction
// SETTLE | bus released for SETTLE_CYCLES, then bus_in captured
module tristate_bus_port
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DRIVE_CYCLES  = 2,
    parameter int TURN_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_done,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] bus_drv,
    input  logic [WIDTH-1:0] bus_in,
    output logic             busy,
    output logic             err
);

    localparam int CW = cnt_width(DRIVE_CYCLES, TURN_CYCLES, SETTLE_CYCLES);
    localparam logic [CW-1:0] DRIVE_LD  = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    bus_state_t       state;
    logic [WIDTH-1:0] data_q;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CW-1:0]    cnt_load_val;
    logic             cnt_zero;

    bus_cycle_counter #(
        .CW (CW)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // The counter is reloaded on the same edge as each transition into a
    // timed state, mirroring the next-state decisions below.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = DRIVE_LD;
                end else if (rd_req) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LD;
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = TURN_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            TURN, SETTLE: cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

`ifdef BUS_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            data_q  <= '0;
            rd_data <= '0;
            rd_done <= 1'b0;
`ifdef BUS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Write wins a tie; rd_req is a level and stays pending.
                    if (wr_valid) begin
                        data_q <= wr_data;
                        state  <= DRIVE;
                    end else if (rd_req) begin
                        state <= SETTLE;
                    end
                end
                DRIVE: begin
                    if (cnt_zero) begin
                        state <= TURN;
`ifdef BUS_CHECK_EN
                        // Case inequality so x/z contention counts as an error.
                        if (bus_in !== data_q) err_q <= 1'b1;
`endif
                    end
                end
                TURN: begin
                    if (cnt_zero) state <= IDLE;
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        rd_data <= bus_in;
                        rd_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_drv  = (state == DRIVE) ? data_q : {WIDTH{1'bz}};
    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
